// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_pkg
//  Purpose  : Shared types for the RSA modular-exponentiation sequencer:
//             multiplier opcodes, sequencer states and small decode helpers.
//  Revision : 1.0  initial release
// ============================================================================
package rsa_pkg;

   localparam int EXP_W = 4096;

   typedef enum logic [1:0] {
      OP_INIT = 2'd0,
      OP_SQR  = 2'd1,
      OP_MUL  = 2'd2,
      OP_FIN  = 2'd3
   } mul_op_t;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_INIT  = 4'd1,
      ST_INITW = 4'd2,
      ST_FETCH = 4'd3,
      ST_FWAIT = 4'd4,
      ST_SQR   = 4'd5,
      ST_SQW   = 4'd6,
      ST_MUL   = 4'd7,
      ST_MULW  = 4'd8,
      ST_NEXT  = 4'd9,
      ST_FIN   = 4'd10,
      ST_FINW  = 4'd11,
      ST_DONE  = 4'd12,
      ST_DRAIN = 4'd13
   } modexp_state_t;

   // States that present a request to the multiplier
   function automatic logic is_issue(modexp_state_t s);
      return (s == ST_INIT) || (s == ST_SQR) || (s == ST_MUL) || (s == ST_FIN);
   endfunction

   // States in which a completion pulse from the multiplier is legitimate
   function automatic logic is_wait(modexp_state_t s);
      return (s == ST_INITW) || (s == ST_SQW) || (s == ST_MULW) ||
             (s == ST_FINW) || (s == ST_DRAIN);
   endfunction

   // Opcode carried by each issue state
   function automatic mul_op_t op_of(modexp_state_t s);
      mul_op_t op;
      case (s)
         ST_SQR:  op = OP_SQR;
         ST_MUL:  op = OP_MUL;
         ST_FIN:  op = OP_FIN;
         default: op = OP_INIT;
      endcase
      return op;
   endfunction

   // Wait state that follows an accepted request from each issue state
   function automatic modexp_state_t wait_of(modexp_state_t s);
      modexp_state_t w;
      case (s)
         ST_SQR:  w = ST_SQW;
         ST_MUL:  w = ST_MULW;
         ST_FIN:  w = ST_FINW;
         default: w = ST_INITW;
      endcase
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_exp_bit_src.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_exp_bit_src
//  Purpose  : Exponent bit source. Issues word reads to the key buffer,
//             holds the fetched 32-bit word and selects the current bit.
//  Revision : 1.0  initial release
// ============================================================================
module rsa_exp_bit_src
   import rsa_pkg::*;
#(
   parameter int AW = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fetch,
   input  logic          capture,
   input  logic [AW+4:0] idx,
   output logic          exp_rd_o,
   output logic [AW-1:0] exp_addr_o,
   input  logic [31:0]   exp_word_i,
   output logic          bit_val
);

   logic [31:0] word_q;

   assign exp_rd_o   = fetch;
   assign exp_addr_o = idx[AW+4:5];
   assign bit_val    = word_q[idx[4:0]];

   // Hold the exponent word returned one cycle after the read strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= '0;
      end else if (capture) begin
         word_q <= exp_word_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rsa_modexp_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_modexp_seq
//  Purpose  : Left-to-right square-and-multiply sequencer driving a shared
//             Montgomery multiplier, one operation outstanding at a time.
//  Revision : 1.0  initial release
// ============================================================================
module rsa_modexp_seq
   import rsa_pkg::*;
#(
   parameter int EXP_W = rsa_pkg::EXP_W,
   parameter int LEN_W = $clog2(EXP_W + 1),
   parameter int AW    = $clog2(EXP_W / 32)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [LEN_W-1:0] exp_len_i,
   output logic             exp_rd_o,
   output logic [AW-1:0]    exp_addr_o,
   input  logic [31:0]      exp_word_i,
   output logic             mul_req_o,
   output logic [1:0]       mul_op_o,
   input  logic             mul_ack_i,
   input  logic             mul_done_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [LEN_W-1:0] bits_left_o
);

   modexp_state_t    state_q;
   logic [LEN_W-1:0] idx_q;
   logic             req_q;
   mul_op_t          op_q;
   logic             err_q;
   logic             bit_val;
   logic             in_wait;
   logic             in_issue;

   assign in_wait  = is_wait(state_q);
   assign in_issue = is_issue(state_q);

   rsa_exp_bit_src #(
      .AW (AW)
   ) u_bit_src (
      .clk        (clk),
      .rst        (rst),
      .fetch      ((state_q == ST_FETCH) && !stall),
      .capture    (state_q == ST_FWAIT),
      .idx        (idx_q[AW+4:0]),
      .exp_rd_o   (exp_rd_o),
      .exp_addr_o (exp_addr_o),
      .exp_word_i (exp_word_i),
      .bit_val    (bit_val)
   );

   assign mul_req_o   = req_q;
   assign mul_op_o    = op_q;
   assign err_o       = err_q;
   assign done_o      = (state_q == ST_DONE);
   assign busy_o      = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign bits_left_o = busy_o ? (idx_q + LEN_W'(1)) : '0;

   // Sequencer FSM: bit index, multiplier handshake and error tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         req_q   <= 1'b0;
         op_q    <= OP_INIT;
         err_q   <= 1'b0;
      end else begin
         if (abort_i && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            // An op the multiplier has accepted must complete before we go idle
            req_q <= 1'b0;
            if ((in_wait && !mul_done_i) || (in_issue && req_q && mul_ack_i)) begin
               state_q <= ST_DRAIN;
            end else begin
               state_q <= ST_IDLE;
            end
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start_i && !abort_i) begin
                     err_q <= 1'b0;
                     if ((exp_len_i == '0) || (exp_len_i > LEN_W'(EXP_W))) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                     end else begin
                        idx_q   <= exp_len_i - LEN_W'(1);
                        state_q <= ST_INIT;
                     end
                  end
               end
               ST_INIT, ST_SQR, ST_MUL, ST_FIN: begin
                  // Request is raised only when not stalled; once up it holds until ack
                  if (req_q) begin
                     if (mul_ack_i) begin
                        req_q   <= 1'b0;
                        state_q <= wait_of(state_q);
                     end
                  end else if (!stall) begin
                     req_q <= 1'b1;
                     op_q  <= op_of(state_q);
                  end
               end
               ST_INITW: if (mul_done_i) state_q <= ST_FETCH;
               ST_FETCH: if (!stall) state_q <= ST_FWAIT;
               ST_FWAIT: state_q <= ST_SQR;
               ST_SQW: begin
                  if (mul_done_i) state_q <= bit_val ? ST_MUL : ST_NEXT;
               end
               ST_MULW: if (mul_done_i) state_q <= ST_NEXT;
               ST_NEXT: begin
                  if (idx_q == '0) begin
                     state_q <= ST_FIN;
                  end else begin
                     idx_q <= idx_q - LEN_W'(1);
                     // Crossing into the next lower word needs a fresh fetch
                     state_q <= (idx_q[4:0] == 5'd0) ? ST_FETCH : ST_SQR;
                  end
               end
               ST_FINW:  if (mul_done_i) state_q <= ST_DONE;
               ST_DONE:  state_q <= ST_IDLE;
               ST_DRAIN: if (mul_done_i) state_q <= ST_IDLE;
               default:  state_q <= ST_IDLE;
            endcase
         end
         // A completion with no accepted op in flight is a protocol error
         if (mul_done_i && !in_wait) begin
            err_q <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rsa_modexp_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rsa_modexp_seq
//  Purpose  : Self-checking bench for rsa_modexp_seq with a multiplier and
//             key-buffer responder and a square-and-multiply reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rsa_modexp_seq;

   localparam int EXP_W = 4096;
   localparam int LEN_W = 13;
   localparam int AW    = 7;
   localparam int BUDGET = 60000;

   logic             clk;
   logic             rst;
   logic             stall;
   logic             start_i;
   logic             abort_i;
   logic [LEN_W-1:0] exp_len_i;
   logic             exp_rd_o;
   logic [AW-1:0]    exp_addr_o;
   logic [31:0]      exp_word_i;
   logic             mul_req_o;
   logic [1:0]       mul_op_o;
   logic             mul_ack_i;
   logic             mul_done_i;
   logic             busy_o;
   logic             done_o;
   logic             err_o;
   logic [LEN_W-1:0] bits_left_o;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [128];
   int ack_lat  = 0;
   int done_lat = 3;
   bit stall_en = 0;
   int spur_cnt = 0;

   int ops_q[$];
   int reads_q[$];
   int done_pulses  = 0;
   int req_cycles   = 0;
   int stab_bad     = 0;
   int mdone_pulses = 0;

   rsa_modexp_seq #(
      .EXP_W (EXP_W),
      .LEN_W (LEN_W),
      .AW    (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .exp_len_i   (exp_len_i),
      .exp_rd_o    (exp_rd_o),
      .exp_addr_o  (exp_addr_o),
      .exp_word_i  (exp_word_i),
      .mul_req_o   (mul_req_o),
      .mul_op_o    (mul_op_o),
      .mul_ack_i   (mul_ack_i),
      .mul_done_i  (mul_done_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .bits_left_o (bits_left_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Random stall, changed just after the rising edge
   initial begin : stall_gen
      stall = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         stall = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
      end
   end

   // Key buffer and output monitor
   initial begin : mem_model
      exp_word_i = '0;
      forever begin
         @(negedge clk);
         if (exp_rd_o) begin
            reads_q.push_back(int'(exp_addr_o));
            exp_word_i = mem[exp_addr_o];
         end
         if (done_o)    done_pulses++;
         if (mul_req_o) req_cycles++;
      end
   end

   // Multiplier: ack after ack_lat held cycles, done pulse done_lat cycles after ack
   initial begin : mul_model
      int hold_cnt = 0;
      int done_cnt = 0;
      int spur_seen = 0;
      bit holding = 0;
      bit ack_now = 0;
      logic [1:0] held_op = '0;
      logic [1:0] acked_op = '0;
      mul_ack_i  = 1'b0;
      mul_done_i = 1'b0;
      forever begin
         @(negedge clk);
         mul_done_i = 1'b0;
         if (ack_now) begin
            ack_now   = 0;
            mul_ack_i = 1'b0;
            ops_q.push_back(int'(acked_op));
            done_cnt  = done_lat;
         end
         if (spur_seen != spur_cnt) begin
            spur_seen  = spur_cnt;
            mul_done_i = 1'b1;
         end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
               mul_done_i = 1'b1;
               mdone_pulses++;
            end
         end else if (mul_req_o) begin
            if (!holding) begin
               holding  = 1;
               hold_cnt = ack_lat;
               held_op  = mul_op_o;
            end else if (mul_op_o !== held_op) begin
               stab_bad++;
            end
            if (hold_cnt == 0) begin
               mul_ack_i = 1'b1;
               ack_now   = 1;
               acked_op  = mul_op_o;
               holding   = 0;
            end else begin
               hold_cnt--;
            end
         end else if (holding) begin
            holding = 0;
            stab_bad++;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One full exponentiation checked against the square-and-multiply model
   task automatic run_exp(input string tag, input int len, input int alat, input int dlat, input bit stl);
      int exp_ops[$];
      int exp_reads[$];
      int ob, rb, db, n, first_bad, got;
      logic [31:0] w;
      exp_ops.push_back(0);
      for (int i = len - 1; i >= 0; i--) begin
         w = mem[i / 32];
         exp_ops.push_back(1);
         if (w[i % 32]) exp_ops.push_back(2);
      end
      exp_ops.push_back(3);
      for (int k = (len - 1) / 32; k >= 0; k--) exp_reads.push_back(k);

      ack_lat  = alat;
      done_lat = dlat;
      stall_en = stl;
      ob = ops_q.size();
      rb = reads_q.size();
      db = done_pulses;
      exp_len_i = LEN_W'(len);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check({tag, " busy"}, busy_o, 1);
      check({tag, " bits_left"}, bits_left_o, len);
      n = 0;
      while ((done_pulses == db) && (n < BUDGET)) begin
         step();
         n++;
      end
      check({tag, " finished in budget"}, (n < BUDGET), 1);
      step();
      step();
      stall_en = 0;
      check({tag, " done pulses"}, done_pulses - db, 1);
      check({tag, " err"}, err_o, 0);
      check({tag, " idle busy"}, busy_o, 0);
      check({tag, " idle bits_left"}, bits_left_o, 0);
      got = ops_q.size() - ob;
      check({tag, " op count"}, got, exp_ops.size());
      first_bad = -1;
      for (int i = 0; i < got && i < exp_ops.size(); i++) begin
         if ((first_bad < 0) && (ops_q[ob + i] != exp_ops[i])) first_bad = i;
      end
      check({tag, " first op mismatch index"}, first_bad, -1);
      got = reads_q.size() - rb;
      check({tag, " read count"}, got, exp_reads.size());
      first_bad = -1;
      for (int i = 0; i < got && i < exp_reads.size(); i++) begin
         if ((first_bad < 0) && (reads_q[rb + i] != exp_reads[i])) first_bad = i;
      end
      check({tag, " first read mismatch index"}, first_bad, -1);
   endtask

   initial begin : main
      int rq, rb, db, ob, mdb, sb, n, len;
      rst       = 1'b1;
      start_i   = 1'b0;
      abort_i   = 1'b0;
      exp_len_i = '0;
      for (int i = 0; i < 128; i++) mem[i] = '0;
      step();
      step();
      check("reset busy", busy_o, 0);
      check("reset done", done_o, 0);
      check("reset err", err_o, 0);
      check("reset req", mul_req_o, 0);
      check("reset rd", exp_rd_o, 0);
      check("reset bits_left", bits_left_o, 0);
      rst = 1'b0;
      step();

      // 1: five-bit exponent 10001
      mem[0] = 32'h11;
      run_exp("t1", 5, 0, 3, 0);

      // 2: 33-bit exponent spanning two words
      mem[1] = 32'h1;
      mem[0] = 32'h0;
      run_exp("t2", 33, 0, 2, 0);

      // 3: rejected lengths
      rq = req_cycles;
      rb = reads_q.size();
      db = done_pulses;
      exp_len_i = '0;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("t3 len0 done", done_o, 1);
      check("t3 len0 err", err_o, 1);
      check("t3 len0 busy", busy_o, 0);
      step();
      check("t3 len0 done drops", done_o, 0);
      exp_len_i = LEN_W'(4097);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("t3 len4097 done", done_o, 1);
      check("t3 len4097 err", err_o, 1);
      step();
      step();
      check("t3 done pulses", done_pulses - db, 2);
      check("t3 no req", req_cycles - rq, 0);
      check("t3 no reads", reads_q.size() - rb, 0);

      // 4: slow ack with stall toggling
      mem[0] = 32'h11;
      sb = stab_bad;
      run_exp("t4", 5, 10, 3, 1);
      check("t4 req/op stable", stab_bad - sb, 0);

      // 5: abort in SQW, drain, then clean rerun
      ack_lat  = 0;
      done_lat = 8;
      ob = ops_q.size();
      db = done_pulses;
      exp_len_i = LEN_W'(5);
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      n = 0;
      while ((ops_q.size() < ob + 2) && (n < 200)) begin
         step();
         n++;
      end
      check("t5 reached sqr wait", ops_q.size() - ob, 2);
      mdb = mdone_pulses;
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      check("t5 draining busy", busy_o, 1);
      n = 0;
      while (busy_o && (n < 200)) begin
         step();
         n++;
      end
      check("t5 drain ended", busy_o, 0);
      check("t5 drained on done", mdone_pulses - mdb, 1);
      step();
      step();
      check("t5 no done", done_pulses - db, 0);
      check("t5 no extra op", ops_q.size() - ob, 2);
      check("t5 err", err_o, 0);
      run_exp("t5 rerun", 5, 0, 3, 0);

      // random lengths and words against the model
      for (int r = 0; r < 4; r++) begin
         len = $urandom_range(1, 200);
         for (int i = 0; i < 128; i++) mem[i] = $urandom;
         run_exp($sformatf("rand%0d", r), len, $urandom_range(0, 3), $urandom_range(1, 4),
                 ($urandom_range(0, 1) == 1));
      end

      // 6: spurious done in IDLE, then full-width all-ones exponent
      db = done_pulses;
      spur_cnt++;
      step();
      step();
      check("t6 spurious err", err_o, 1);
      check("t6 spurious busy", busy_o, 0);
      check("t6 spurious no done", done_pulses - db, 0);
      for (int i = 0; i < 128; i++) mem[i] = 32'hFFFF_FFFF;
      run_exp("t6", 4096, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
